// File: rtl/microwave_timer.sv
// Microwave countdown core: BCD keypad entry, 1 Hz countdown, magnetron enable.
// Outputs are registered; one event per cycle acts, chosen by a fixed priority.
module microwave_timer #(
    parameter int unsigned MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] bmin,
    output logic [3:0] bsec_tens,
    output logic [3:0] bsec_ones,
    output logic       mag_on,
    output logic       done,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] MAX_MIN_L = 4'(MAX_MIN);

    state_t     state_q, state_d;
    logic [3:0] bmin_q, bmin_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       mag_q, mag_d;
    logic       done_q, done_d;

    logic        key_ok_s;
    logic        shift_ok_s;
    logic        time_zero_s;
    logic [11:0] dec_s;

    // One-second BCD decrement of {minutes, tens, ones} with borrow chain.
    function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] t,
                                            input logic [3:0] o);
        logic [3:0] mm;
        logic [3:0] tt;
        logic [3:0] oo;
        mm = m;
        tt = t;
        oo = o;
        if (o != 4'd0) begin
            oo = o - 4'd1;
        end else begin
            oo = 4'd9;
            if (t != 4'd0) begin
                tt = t - 4'd1;
            end else begin
                tt = 4'd5;
                mm = m - 4'd1;
            end
        end
        return {mm, tt, oo};
    endfunction

    assign key_ok_s    = key_valid && (key_value <= 4'd9);
    assign shift_ok_s  = (ones_q <= 4'd5) && (tens_q <= MAX_MIN_L);
    assign time_zero_s = (bmin_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign dec_s       = bcd_dec(bmin_q, tens_q, ones_q);

    // Next-state and next-digit selection, highest-priority applicable event wins.
    always_comb begin
        state_d = state_q;
        bmin_d  = bmin_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stop_clear) begin
                    bmin_d = 4'd0;
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end else if (start && door_closed && !time_zero_s) begin
                    state_d = RUN;
                end else if (key_ok_s && shift_ok_s) begin
                    bmin_d = tens_q;
                    tens_d = ones_q;
                    ones_d = key_value;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (stop_clear || !door_closed) begin
                    state_d = PAUSE;
                end else if (tick_1hz) begin
                    bmin_d = dec_s[11:8];
                    tens_d = dec_s[7:4];
                    ones_d = dec_s[3:0];
                    if (dec_s == 12'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    state_d = IDLE;
                    bmin_d  = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else if (start && door_closed) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            DONE: begin
                // Digits are already 0:00 here, so a key simply becomes the ones digit.
                if (stop_clear) begin
                    state_d = IDLE;
                end else if (key_ok_s) begin
                    state_d = IDLE;
                    ones_d  = key_value;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                bmin_d  = 4'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end
        endcase
        mag_d = (state_d == RUN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bmin_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bmin_q  <= bmin_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            mag_q   <= mag_d;
            done_q  <= done_d;
        end
    end

    assign bmin      = bmin_q;
    assign bsec_tens = tens_q;
    assign bsec_ones = ones_q;
    assign mag_on    = mag_q;
    assign done      = done_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer: seconds-count reference model compared every cycle,
// directed literal checks, then randomized stimulus.
module tb_microwave_timer;

    localparam int MAX_MIN = 9;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_value;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] bmin;
    logic [3:0] bsec_tens;
    logic [3:0] bsec_ones;
    logic       mag_on;
    logic       done;
    logic [1:0] state_o;

    int n_cmp;
    int n_bad;

    microwave_timer #(.MAX_MIN(MAX_MIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .key_valid  (key_valid),
        .key_value  (key_value),
        .start      (start),
        .stop_clear (stop_clear),
        .door_closed(door_closed),
        .bmin       (bmin),
        .bsec_tens  (bsec_tens),
        .bsec_ones  (bsec_ones),
        .mag_on     (mag_on),
        .done       (done),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model keeps cook time as a plain number of seconds; mode 0 idle,1 run,2 pause,3 done.
    typedef struct packed {
        logic [9:0] t;
        logic [1:0] mode;
        logic       mag;
        logic       dn;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic sc, logic dr, logic st,
                                           logic tk, logic kv, logic [3:0] kval);
        mstate_t n;
        int t;
        int tens;
        int ones;
        bit key_ok;
        n    = s;
        n.dn = 1'b0;
        t    = int'(s.t);
        tens = (t % 60) / 10;
        ones = t % 10;
        key_ok = kv && (kval <= 4'd9);
        case (s.mode)
            2'd0: begin
                if (sc) t = 0;
                else if (st && dr && t != 0) n.mode = 2'd1;
                else if (key_ok && ones <= 5 && tens <= MAX_MIN) t = tens * 60 + ones * 10 + int'(kval);
            end
            2'd1: begin
                if (sc || !dr) n.mode = 2'd2;
                else if (tk) begin
                    t = t - 1;
                    if (t == 0) begin
                        n.mode = 2'd3;
                        n.dn   = 1'b1;
                    end
                end
            end
            2'd2: begin
                if (sc) begin
                    n.mode = 2'd0;
                    t = 0;
                end else if (st && dr) n.mode = 2'd1;
            end
            default: begin
                if (sc) n.mode = 2'd0;
                else if (key_ok) begin
                    n.mode = 2'd0;
                    t = int'(kval);
                end
            end
        endcase
        n.t   = 10'(t);
        n.mag = (n.mode == 2'd1);
        return n;
    endfunction

    function automatic logic [15:0] model_vec(mstate_t s);
        int t;
        t = int'(s.t);
        return {4'(t / 60), 4'((t % 60) / 10), 4'(t % 10), s.mode, s.mag, s.dn};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {bmin, bsec_tens, bsec_ones, state_o, mag_on, done};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_next(m, stop_clear, door_closed, start, tick_1hz, key_valid, key_value);
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if (dut_vec() !== model_vec(m)) begin
            n_bad = n_bad + 1;
            $display("FAIL cycle_cmp t=%0t got=%h want=%h (min,tens,ones,state,mag,done)",
                     $time, dut_vec(), model_vec(m));
        end
    end

    task automatic check_lit(input string name, input logic [3:0] em, input logic [3:0] et,
                             input logic [3:0] eo, input logic [1:0] es, input logic emag,
                             input logic edn);
        logic [15:0] exp_v;
        exp_v = {em, et, eo, es, emag, edn};
        n_cmp = n_cmp + 1;
        if (dut_vec() !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s dut got=%h want=%h", name, dut_vec(), exp_v);
        end
        n_cmp = n_cmp + 1;
        if (model_vec(m) !== exp_v) begin
            n_bad = n_bad + 1;
            $display("FAIL %s model got=%h want=%h", name, model_vec(m), exp_v);
        end
    endtask

    // Apply one cycle of inputs and return at the following negedge.
    task automatic step(input logic sc, input logic st, input logic tk, input logic kv,
                        input logic [3:0] kval);
        stop_clear = sc;
        start      = st;
        tick_1hz   = tk;
        key_valid  = kv;
        key_value  = kval;
        @(negedge clk);
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b0, 1'b0, 1'b0, 1'b1, k);
    endtask

    task automatic idle_cyc();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        door_closed = 1'b1;
        stop_clear = 1'b0;
        start = 1'b0;
        tick_1hz = 1'b0;
        key_valid = 1'b0;
        key_value = 4'd0;
        repeat (3) @(negedge clk);
        check_lit("reset_hold", 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle_cyc();
        check_lit("after_reset", 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

        key(4'd1); key(4'd3); key(4'd0);
        check_lit("keys_130", 4'd1, 4'd3, 4'd0, 2'b00, 1'b0, 1'b0);
        key(4'd7);
        check_lit("keys_307", 4'd3, 4'd0, 4'd7, 2'b00, 1'b0, 1'b0);
        key(4'd8);
        check_lit("key_illegal", 4'd3, 4'd0, 4'd7, 2'b00, 1'b0, 1'b0);
        key(4'd12);
        check_lit("key_over9", 4'd3, 4'd0, 4'd7, 2'b00, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        key(4'd1); key(4'd0); key(4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_lit("start_100", 4'd1, 4'd0, 4'd0, 2'b01, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_lit("tick_059", 4'd0, 4'd5, 4'd9, 2'b01, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_lit("tick_057", 4'd0, 4'd5, 4'd7, 2'b01, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check_lit("stop_pause", 4'd0, 4'd5, 4'd7, 2'b10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check_lit("stop_clear", 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);

        key(4'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_lit("tick_001", 4'd0, 4'd0, 4'd1, 2'b01, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_lit("reach_done", 4'd0, 4'd0, 4'd0, 2'b11, 1'b0, 1'b1);
        idle_cyc();
        check_lit("done_pulse_end", 4'd0, 4'd0, 4'd0, 2'b11, 1'b0, 1'b0);
        key(4'd4);
        check_lit("done_key", 4'd0, 4'd0, 4'd4, 2'b00, 1'b0, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        key(4'd1); key(4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_lit("tick_009", 4'd0, 4'd0, 4'd9, 2'b01, 1'b1, 1'b0);
        door_closed = 1'b0;
        idle_cyc();
        check_lit("door_pause", 4'd0, 4'd0, 4'd9, 2'b10, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check_lit("pause_hold", 4'd0, 4'd0, 4'd9, 2'b10, 1'b0, 1'b0);
        door_closed = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_lit("resume", 4'd0, 4'd0, 4'd9, 2'b01, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_lit("tick_008", 4'd0, 4'd0, 4'd8, 2'b01, 1'b1, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_lit("start_zero", 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        key(4'd5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check_lit("start_tick", 4'd0, 4'd0, 4'd5, 2'b01, 1'b1, 1'b0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        key(4'd2); key(4'd1); key(4'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_lit("run_215", 4'd2, 4'd1, 4'd5, 2'b01, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_lit("async_reset", 4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cyc();

        // Randomized phase: the per-cycle compare process does the checking.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)));
        end
        idle_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
